// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner ids, counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between IF and LS; gnt 1 cycle after sampled req, rvalid MEM_LAT+1 after gnt.
// No queueing: a requester holds req until gnt; reqs seen outside IDLE are ignored, one access in flight.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,

    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wstrb,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,

    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,

    output logic            busy
);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                we_q, we_d;

    logic                if_gnt_q, if_gnt_d;
    logic                ls_gnt_q, ls_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic [DW-1:0]       ls_rdata_q, ls_rdata_d;

    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0]     mem_wstrb_q, mem_wstrb_d;

    logic                win;

    // A tie goes to whoever did not own the previous access.
    function automatic logic pick_owner(input logic ifr, input logic lsr, input logic last);
        if (ifr && lsr) begin
            return (last == OWN_IF) ? OWN_LS : OWN_IF;
        end
        return lsr ? OWN_LS : OWN_IF;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_gnt_d     = 1'b0;
        ls_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        ls_rvalid_d  = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_wstrb_d  = '0;
        win          = pick_owner(if_req, ls_req, last_owner_q);

        case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    owner_d      = win;
                    last_owner_d = win;
                    cnt_d        = CNT_W'(MEM_LAT);
                    state_d      = ST_WAIT;
                    mem_en_d     = 1'b1;
                    if (win == OWN_IF) begin
                        if_gnt_d   = 1'b1;
                        we_d       = 1'b0;
                        mem_addr_d = if_addr;
                    end else begin
                        ls_gnt_d    = 1'b1;
                        we_d        = ls_we;
                        mem_we_d    = ls_we;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                        mem_wstrb_d = ls_wstrb;
                    end
                end
            end

            // cnt runs MEM_LAT..0 so the capture edge closes the cycle in which mem_rdata is valid.
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = we_q ? '0 : mem_rdata;
                    end else begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = we_q ? '0 : mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_LS;
            we_q         <= 1'b0;
            if_gnt_q     <= 1'b0;
            ls_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            if_gnt_q     <= if_gnt_d;
            ls_gnt_q     <= ls_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
